// File: rtl/pc_branch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_branch_ctrl_if
// Description : Run handshake, fetch and issue signals between the branch
//               sequencer (master) and the fetch/lane side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_branch_ctrl_if #(
    parameter int PC_W    = 6,
    parameter int INSTR_W = 32
);
    logic               start;
    logic [PC_W-1:0]    program_counter;
    logic [INSTR_W-1:0] instr;
    logic               jmp_en;
    logic [PC_W-1:0]    jmp_target;
    logic               issue_valid;
    logic [INSTR_W-1:0] issue_instr;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        input  start, program_counter, instr,
        output jmp_en, jmp_target, issue_valid, issue_instr, busy, done, err
    );

    modport slave (
        output start, program_counter, instr,
        input  jmp_en, jmp_target, issue_valid, issue_instr, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/pc_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_branch_ctrl
// Description : Control-op sequencer for program_counter: decodes JMP, LOOP,
//               ENDL and HALT, redirects the PC, issues EXEC words and squashes
//               the one wrong-path fetch after every redirect.
//               NESTED_LOOP_EN: 4-entry loop stack instead of a single entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_branch_ctrl #(
    parameter int          PC_W       = 6,
    parameter int          INSTR_W    = 32,
    parameter int          CNT_W      = 8,
    parameter int unsigned START_ADDR = 0
) (
    input  logic             clk,
    input  logic             rst,
    pc_branch_ctrl_if.master bus
);

`ifdef NESTED_LOOP_EN
    localparam int c_STACK_DEPTH = 4;
`else
    localparam int c_STACK_DEPTH = 1;
`endif
    localparam int c_SP_W = $clog2(c_STACK_DEPTH + 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    localparam logic [2:0] c_OP_EXEC = 3'b000;
    localparam logic [2:0] c_OP_JMP  = 3'b001;
    localparam logic [2:0] c_OP_LOOP = 3'b010;
    localparam logic [2:0] c_OP_ENDL = 3'b011;
    localparam logic [2:0] c_OP_HALT = 3'b111;

    localparam logic [PC_W-1:0]   c_START   = PC_W'(START_ADDR);
    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);
    localparam logic [c_SP_W-1:0] c_SP_ONE  = c_SP_W'(1);
    localparam logic [c_SP_W-1:0] c_SP_FULL = c_SP_W'(c_STACK_DEPTH);

    logic [0:0]        r_state;
    logic              r_squash;
    logic [PC_W-1:0]   r_pc;
    logic              r_err;
    logic [c_SP_W-1:0] r_sp;
    // Entry 0 is always the top of the stack; push/pop shift the others.
    logic [PC_W-1:0]   r_loop_start [c_STACK_DEPTH];
    logic [CNT_W-1:0]  r_loop_cnt   [c_STACK_DEPTH];

    logic [0:0]        w_state_nxt;
    logic              w_squash_nxt;
    logic              w_jmp_en;
    logic [PC_W-1:0]   w_jmp_target;
    logic              w_issue_valid;
    logic              w_done;
    logic              w_err_set;
    logic              w_push;
    logic              w_pop;
    logic              w_dec;
    logic              w_clear;

    logic [2:0]        w_opcode;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_push_cnt;
    logic [PC_W-1:0]   w_push_start;
    logic              w_active;
    logic              w_full;

    assign w_opcode     = bus.instr[INSTR_W-1 -: 3];
    assign w_count      = bus.instr[CNT_W-1:0];
    assign w_push_cnt   = (w_count == '0) ? c_CNT_ONE : w_count;
    assign w_push_start = r_pc + PC_W'(1);
    assign w_active     = (r_sp != '0);
    assign w_full       = (r_sp == c_SP_FULL);

    always_comb begin
        w_state_nxt   = r_state;
        w_squash_nxt  = r_squash;
        w_jmp_en      = 1'b0;
        w_jmp_target  = c_START;
        w_issue_valid = 1'b0;
        w_done        = 1'b0;
        w_err_set     = 1'b0;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_dec         = 1'b0;
        w_clear       = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_jmp_en = 1'b1;
                if (bus.start) begin
                    w_state_nxt  = c_RUN;
                    w_squash_nxt = 1'b1;
                    w_clear      = 1'b1;
                end
            end
            default: begin
                if (r_squash) begin
                    w_squash_nxt = 1'b0;
                end else begin
                    case (w_opcode)
                        c_OP_EXEC: w_issue_valid = 1'b1;
                        c_OP_JMP: begin
                            w_jmp_en     = 1'b1;
                            w_jmp_target = bus.instr[PC_W-1:0];
                            w_squash_nxt = 1'b1;
                        end
                        c_OP_LOOP: begin
                            w_err_set = w_full;
`ifdef NESTED_LOOP_EN
                            w_push    = !w_full;
`else
                            w_push    = 1'b1;
`endif
                        end
                        c_OP_ENDL: begin
                            if (!w_active) begin
                                w_err_set = 1'b1;
                            end else if (r_loop_cnt[0] > c_CNT_ONE) begin
                                w_dec        = 1'b1;
                                w_jmp_en     = 1'b1;
                                w_jmp_target = r_loop_start[0];
                                w_squash_nxt = 1'b1;
                            end else begin
                                w_pop = 1'b1;
                            end
                        end
                        c_OP_HALT: begin
                            w_done       = 1'b1;
                            w_state_nxt  = c_IDLE;
                            w_squash_nxt = 1'b1;
                        end
                        default: w_err_set = 1'b1;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_squash <= 1'b1;
            r_pc     <= '0;
            r_err    <= 1'b0;
            r_sp     <= '0;
            for (int i = 0; i < c_STACK_DEPTH; i++) begin
                r_loop_start[i] <= '0;
                r_loop_cnt[i]   <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_squash <= w_squash_nxt;
            r_pc     <= bus.program_counter;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_clear) begin
                r_sp <= '0;
            end else if (w_push) begin
                for (int i = c_STACK_DEPTH - 1; i > 0; i--) begin
                    r_loop_start[i] <= r_loop_start[i-1];
                    r_loop_cnt[i]   <= r_loop_cnt[i-1];
                end
                r_loop_start[0] <= w_push_start;
                r_loop_cnt[0]   <= w_push_cnt;
                // A single-entry stack overwrites in place, so its depth stays at one.
                if (!w_full) begin
                    r_sp <= r_sp + c_SP_ONE;
                end
            end else if (w_pop) begin
                for (int i = 0; i < c_STACK_DEPTH - 1; i++) begin
                    r_loop_start[i] <= r_loop_start[i+1];
                    r_loop_cnt[i]   <= r_loop_cnt[i+1];
                end
                r_sp <= r_sp - c_SP_ONE;
            end else if (w_dec) begin
                r_loop_cnt[0] <= r_loop_cnt[0] - c_CNT_ONE;
            end
        end
    end

    assign bus.jmp_en      = w_jmp_en;
    assign bus.jmp_target  = w_jmp_target;
    assign bus.issue_valid = w_issue_valid;
    assign bus.issue_instr = bus.instr;
    assign bus.busy        = (r_state == c_RUN);
    assign bus.done        = w_done;
    assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_branch_ctrl
// Description : Random and directed programs run through a PC/ROM model; an
//               ISA-level interpreter predicts issue, redirect and done events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_branch_ctrl;
    localparam int PC_W    = 6;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 8;
`ifdef NESTED_LOOP_EN
    localparam int c_DEPTH = 4;
`else
    localparam int c_DEPTH = 1;
`endif
    localparam int c_EV_ISSUE = 0;
    localparam int c_EV_JUMP  = 1;
    localparam int c_EV_DONE  = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          t;
    } ev_t;

    ev_t exp_q[$];

    logic               clk     = 1'b0;
    logic               rst     = 1'b1;
    logic [PC_W-1:0]    pc_r    = '0;
    logic [INSTR_W-1:0] instr_r = '0;
    logic [31:0]        mem [64];
    int                 cyc       = 0;
    int                 start_cyc = 0;
    int                 checks    = 0;
    int                 failures  = 0;
    bit                 model_err = 1'b0;

    pc_branch_ctrl_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    pc_branch_ctrl #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W), .START_ADDR(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.program_counter = pc_r;
    assign bus.instr           = instr_r;

    always #5 clk = ~clk;

    // program_counter and synchronous instruction ROM
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        pc_r    <= bus.jmp_en ? bus.jmp_target : pc_r + PC_W'(1);
        instr_r <= mem[pc_r];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input logic [31:0] data, input int t);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.t    = t;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: actual=kind%0d data=%0h required=none (cycle %0d)",
                     kind, data, cyc);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        check("event_data", data, e.data);
        check("event_time", 32'(cyc - start_cyc), 32'(e.t));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.issue_valid)           expect_ev(c_EV_ISSUE, bus.issue_instr);
            if (bus.busy && bus.jmp_en)    expect_ev(c_EV_JUMP, 32'(bus.jmp_target));
            if (bus.done)                  expect_ev(c_EV_DONE, 32'd0);
        end
    end

    // Instruction-level interpreter: one cycle per executed word, one extra per redirect.
    task automatic model_run();
        int          pc    = 0;
        int          t     = 2;
        int          c;
        logic [31:0] w;
        int          ls[$];
        int          lc[$];
        for (int steps = 0; steps < 4000; steps++) begin
            w = mem[pc];
            case (w[31:29])
                3'b000: begin push_ev(c_EV_ISSUE, w, t); pc = pc + 1; t = t + 1; end
                3'b001: begin push_ev(c_EV_JUMP, 32'(w[5:0]), t); pc = int'(w[5:0]); t = t + 2; end
                3'b010: begin
                    c = (w[7:0] == 8'd0) ? 1 : int'(w[7:0]);
                    if (ls.size() == c_DEPTH) begin
                        model_err = 1'b1;
                        if (c_DEPTH == 1) begin
                            ls[0] = (pc + 1) % 64;
                            lc[0] = c;
                        end
                    end else begin
                        ls.push_back((pc + 1) % 64);
                        lc.push_back(c);
                    end
                    pc = pc + 1;
                    t  = t + 1;
                end
                3'b011: begin
                    if (ls.size() == 0) begin
                        model_err = 1'b1;
                        pc = pc + 1;
                        t  = t + 1;
                    end else if (lc[lc.size()-1] > 1) begin
                        lc[lc.size()-1] = lc[lc.size()-1] - 1;
                        push_ev(c_EV_JUMP, 32'(ls[ls.size()-1]), t);
                        pc = ls[ls.size()-1];
                        t  = t + 2;
                    end else begin
                        void'(ls.pop_back());
                        void'(lc.pop_back());
                        pc = pc + 1;
                        t  = t + 1;
                    end
                end
                3'b111: begin push_ev(c_EV_DONE, 32'd0, t); return; end
                default: begin model_err = 1'b1; pc = pc + 1; t = t + 1; end
            endcase
            pc = pc % 64;
        end
        $display("FAIL model_termination: actual=no HALT reached required=HALT");
        $fatal(1, "reference program did not terminate");
    endtask

    function automatic logic [31:0] exec_w();       return {3'b000, 29'($urandom)}; endfunction
    function automatic logic [31:0] jmp_w(int tgt); return {3'b001, 23'($urandom), 6'(tgt)}; endfunction
    function automatic logic [31:0] loop_w(int n);  return {3'b010, 21'($urandom), 8'(n)}; endfunction
    function automatic logic [31:0] endl_w();       return {3'b011, 29'($urandom)}; endfunction
    function automatic logic [31:0] halt_w();       return {3'b111, 29'($urandom)}; endfunction
    function automatic logic [31:0] illegal_w();    return {3'($urandom_range(4, 6)), 29'($urandom)}; endfunction

    task automatic fill_junk();
        for (int i = 0; i < 64; i++) mem[i] = exec_w();
    endtask

    // Straight-line items: EXEC, forward JMP over junk, illegal op.
    task automatic gen_leaf(input int pos_in, input int len, output int pos_out);
        int pos;
        int r;
        int skip;
        pos = pos_in;
        for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 5);
            if (r == 0) begin
                skip     = $urandom_range(1, 2);
                mem[pos] = jmp_w(pos + 1 + skip);
                pos      = pos + 1 + skip;
            end else if (r == 1) begin
                mem[pos] = illegal_w();
                pos      = pos + 1;
            end else begin
                mem[pos] = exec_w();
                pos      = pos + 1;
            end
        end
        pos_out = pos;
    endtask

    task automatic gen_loop(input int pos_in, output int pos_out);
        int pos;
        int p;
        int n;
        pos      = pos_in;
        mem[pos] = loop_w($urandom_range(0, 3));
        pos      = pos + 1;
        n        = $urandom_range(1, 2);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                mem[pos] = loop_w($urandom_range(0, 3));
                gen_leaf(pos + 1, $urandom_range(1, 2), p);
                mem[p] = endl_w();
                pos    = p + 1;
            end else begin
                gen_leaf(pos, 1, p);
                pos = p;
            end
        end
        mem[pos] = endl_w();
        pos_out  = pos + 1;
    endtask

    task automatic gen_program();
        int pos;
        int p;
        int r;
        int len;
        fill_junk();
        pos = 0;
        len = $urandom_range(4, 12);
        for (int k = 0; k < len && pos < 52; k++) begin
            r = $urandom_range(0, 7);
            if (r < 2 && pos < 40) begin
                gen_loop(pos, p);
            end else if (r == 2) begin
                mem[pos] = endl_w();
                p        = pos + 1;
            end else begin
                gen_leaf(pos, 1, p);
            end
            pos = p;
        end
        mem[pos] = halt_w();
    endtask

    task automatic check_reset_outputs();
        check("rst_jmp_en",      32'(bus.jmp_en),      32'd1);
        check("rst_jmp_target",  32'(bus.jmp_target),  32'd0);
        check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("rst_busy",        32'(bus.busy),        32'd0);
        check("rst_done",        32'(bus.done),        32'd0);
        check("rst_err",         32'(bus.err),         32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        model_err = 1'b0;
        #1 check_reset_outputs();
        @(posedge clk);
        #1 check("rst_pc_parked", 32'(pc_r), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_prog(input int abort_at, input int start_len);
        int n;
        model_run();
        @(negedge clk);
        bus.start = 1'b1;
        start_cyc = cyc;
        repeat (start_len) @(negedge clk);
        bus.start = 1'b0;
        if (abort_at >= 0) begin
            while (cyc - start_cyc < abort_at) @(negedge clk);
            #1 rst = 1'b1;
            exp_q.delete();
            model_err = 1'b0;
            #1 check_reset_outputs();
            @(negedge clk);
            #1 rst = 1'b0;
            return;
        end
        n = 0;
        #1;
        while ((exp_q.size() != 0 || bus.busy) && n < 2000) begin
            @(negedge clk);
            #1 n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL run_timeout: actual=busy after %0d cycles required=done", n);
        end
        check("events_left",     32'(exp_q.size()),   32'd0);
        check("idle_jmp_en",     32'(bus.jmp_en),     32'd1);
        check("idle_jmp_target", 32'(bus.jmp_target), 32'd0);
        check("err",             32'(bus.err),        32'(model_err));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        fill_junk();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        check("rst_pc_parked", 32'(pc_r), 32'd0);
        #1 rst = 1'b0;

        // straight line then HALT
        fill_junk();
        mem[3] = halt_w();
        run_prog(-1, 1);

        // JMP over a wrong-path word
        fill_junk();
        mem[1] = jmp_w(5);
        mem[6] = halt_w();
        run_prog(-1, 1);

        // counted loop, then LOOP 0
        fill_junk();
        mem[0] = loop_w(3); mem[2] = endl_w(); mem[3] = halt_w();
        run_prog(-1, 1);
        mem[0] = loop_w(0);
        run_prog(-1, 2);

        // ENDL on empty stack and illegal opcode
        fill_junk();
        mem[0] = endl_w();
        mem[1] = {3'b101, 29'($urandom)};
        mem[3] = halt_w();
        run_prog(-1, 1);
        reset_pulse();

        // reset during the second iteration, then a full rerun
        fill_junk();
        mem[0] = loop_w(3); mem[2] = endl_w(); mem[3] = halt_w();
        run_prog(7, 1);
        run_prog(-1, 1);

        // two-level nest, then five levels (overflows the nested stack)
        fill_junk();
        mem[0] = loop_w(2); mem[1] = loop_w(3); mem[3] = endl_w(); mem[4] = endl_w();
        mem[5] = halt_w();
        run_prog(-1, 1);
        fill_junk();
        for (int i = 0; i < 5; i++) mem[i] = loop_w(2);
        for (int i = 6; i < 11; i++) mem[i] = endl_w();
        mem[11] = halt_w();
        run_prog(-1, 1);
        reset_pulse();

        for (int iter = 0; iter < 40; iter++) begin
            gen_program();
            if (iter % 8 == 7) begin
                run_prog($urandom_range(3, 20), 1);
            end else begin
                run_prog(-1, $urandom_range(1, 2));
            end
            if (iter % 5 == 4) reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
